activation_arbiter: RTL and testbench
=====================================

# activation_arbiter

Round-robin arbiter and pipeline controller that shares one LUT-plus-interpolator activation unit among N_REQ neuron requesters of a layer. Each requester presents a Q4.4 signed z value. The arbiter grants one per cycle, pushes it through a two-stage registered pipeline around the combinational activation unit, and returns the activated value tagged with the requester index. It sits between a layer's accumulators and its output buffer. This replaces one activation instance per neuron.

## Interface
- N_REQ, default 4: number of requesters, 2..16
- ID_W, default 2: requester tag width, equal to clog2(N_REQ)
- DATA_W, default 8: signed Q4.4 word width; fixed at 8 to match the activation unit
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- req  in  N_REQ  request per requester; held high with stable z until acked
- z_value  in  N_REQ*DATA_W  packed z values; slice i is requester i
- ack  out  N_REQ  one-hot, one-cycle pulse; z_value[i] is captured at this edge
- a_valid  out  1  result valid
- a_data  out  DATA_W  activated value, signed Q4.4
- a_id  out  ID_W  index of the requester that produced a_data
- a_ready  in  1  downstream accepts the result when a_valid && a_ready
- busy  out  1  high while any pipeline stage holds data

## Operation
- Stage S1 registers: s1_v, s1_z, s1_id. Stage S2 registers: a_valid, a_data, a_id.
- Round-robin pointer `last` (ID_W bits). Search order is last+1, last+2, …, wrapping modulo N_REQ. The first requester with req high wins.
- Advance conditions:
  - s2_adv = !a_valid || a_ready
  - s1_adv = !s1_v || s2_adv
- Grant: when s1_adv is high and any req is high, ack[winner] is asserted combinationally in the same cycle. At the clock edge:
  - s1_z <= winner's z_value
  - s1_id <= winner
  - s1_v <= 1
  - last <= winner
- No grant when s1_adv is low. ack is all-zero, `last` holds, and S1 holds.
- When s1_adv is high and no req is present: s1_v <= 0.
- On s2_adv: a_valid <= s1_v, a_data <= act(s1_z), a_id <= s1_id. When s1_v = 0, a_data and a_id hold their values.
- act(z) is the shared activation sub-module:
  - address = z[7:4], unsigned index into 16 entries
  - remaining = zero-extended z[3:0]
  - change = 8'sd16 (1.0 in Q4.4)
  - output is 8-bit signed; saturation is the sub-module's responsibility
- busy = s1_v || a_valid.
- Reset values (asynchronous, rst low):
  - s1_v = 0, a_valid = 0
  - a_data = 0, a_id = 0, s1_z = 0, s1_id = 0
  - last = N_REQ-1, so requester 0 has priority first
  - ack = 0 while rst is low
- A requester dropping req without an ack loses its turn and is not an error. A requester that raises req in the same cycle it was just acked is treated as a new request.

## Timing
- Latency: ack in cycle T -> a_valid high in cycle T+2 when unstalled.
- Throughput: 1 result per cycle with continuous requests and a_ready = 1.
- Stall: a_valid && !a_ready freezes S2. S1 freezes if it is full. No ack issues while both stages are full. Up to 2 results are buffered, with no loss or duplication.
- Simultaneous a_ready and new grant in one cycle: S2 takes S1 and S1 takes the new request in the same edge.
- Fairness: with all requesters continuously requesting, each gets exactly one ack every N_REQ grants.
- Reset mid-operation: in-flight results are discarded and no a_valid is produced for them. Requesters must re-present after reset.

## Structure
- Shared package holds:
  - the Q4.4 format constants: DATA_W = 8, FRAC_W = 4, ONE = 16
  - the LUT depth constant: 16
  - the function for round-robin next-winner selection
- One sub-module: act_lut_interp, the existing combinational LUT lookup and linear interpolator. Ports: z_value in, a out. Instanced once.
- The arbiter, the two pipeline stages and the stall logic are all in the top module.

## Test plan
- Single request: req = 4'b0100, z_value[2] = 8'sh00, a_ready = 1 -> ack = 4'b0100 in cycle 0; a_valid in cycle 2 with a_id = 2 and a_data = act(0x00), which is the LUT entry 0 base value.
- Round robin: all four req held high for 8 cycles, a_ready = 1 -> ack order is 0,1,2,3,0,1,2,3. Results arrive in the same order, each 2 cycles after its ack.
- Backpressure: continuous req, a_ready = 0 from cycle 3 to cycle 7 -> exactly 2 results buffered and ack = 0 during the stall. After a_ready returns, the results drain in order with no duplicates or losses.
- Interpolation: z = 8'sh18 -> a_data = base[1] + ((next[1] - base[1]) * 8) / 16, matching the golden model of act_lut_interp. z = 8'sh7F -> the top-entry result.
- Reset mid-flight: assert rst low while S1 and S2 are both valid -> a_valid, busy and ack go to 0 immediately. After release, the first grant goes to requester 0.
- Drop without ack: requester 1 raises req for 1 cycle while the pipeline is stalled, then lowers it -> no ack is issued to 1 and no result is produced for 1.

Source files
------------

// File: rtl/activation_arbiter_pkg.sv
// Shared constants and helpers for the activation arbiter slice.
// Q4.4 format, LUT geometry and the round-robin winner search.
package activation_arbiter_pkg;

  localparam int DATA_W    = 8;
  localparam int FRAC_W    = 4;
  localparam int ONE       = 16;
  localparam int LUT_DEPTH = 16;
  localparam int MAX_REQ   = 16;

  // Returns {found, index}; scanning far-to-near lets the nearest requester after 'last' win.
  function automatic logic [4:0] rrNext(input logic [MAX_REQ-1:0] req,
                                        input logic [3:0]         last,
                                        input int                 nReq);
    logic [4:0] result;
    int         idx;
    result = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= nReq) begin
        idx = (int'(last) + i) % nReq;
        if (req[idx]) result = {1'b1, 4'(idx)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/activation_arbiter_act.sv
// Combinational sigmoid activation: 16-entry LUT on the integer part of a Q4.4 z,
// linearly interpolated on the fractional part and saturated to 8 bits.
module act_lut_interp
  import activation_arbiter_pkg::*;
(
  input  logic signed [DATA_W-1:0] z_value,
  output logic signed [DATA_W-1:0] a
);

  logic [3:0]        w_addr;
  logic [3:0]        w_addr_next;
  logic [FRAC_W-1:0] w_rem;
  logic signed [15:0] w_base;
  logic signed [15:0] w_next;
  logic signed [15:0] w_prod;
  logic signed [15:0] w_sum;

  function automatic logic signed [DATA_W-1:0] lutVal(input logic [3:0] addr);
    case (addr)
      4'd0:    lutVal = 8'sd8;
      4'd1:    lutVal = 8'sd12;
      4'd2:    lutVal = 8'sd14;
      4'd3:    lutVal = 8'sd15;
      4'd4, 4'd5, 4'd6, 4'd7: lutVal = 8'sd16;
      4'd13:   lutVal = 8'sd1;
      4'd14:   lutVal = 8'sd2;
      4'd15:   lutVal = 8'sd4;
      default: lutVal = 8'sd0;
    endcase
  endfunction

  assign w_addr = z_value[DATA_W-1:FRAC_W];
  assign w_rem  = z_value[FRAC_W-1:0];
  // Entry 7 is the most positive z; it interpolates flat instead of wrapping to z = -8.
  assign w_addr_next = (w_addr == 4'd7) ? w_addr : w_addr + 4'd1;

  always_comb begin
    w_base = 16'(lutVal(w_addr));
    w_next = 16'(lutVal(w_addr_next));
    w_prod = (w_next - w_base) * $signed(16'(w_rem));
    w_sum  = w_base + w_prod / 16'(ONE);
    if (w_sum > 16'sd127)       a = 8'sd127;
    else if (w_sum < -16'sd128) a = 8'sh80;
    else                        a = w_sum[DATA_W-1:0];
  end

endmodule

// File: rtl/activation_arbiter.sv
// Round-robin sharing of one activation unit among N_REQ requesters,
// with a two-stage stallable pipeline returning tagged results.
module activation_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] z_value,
  output logic [N_REQ-1:0]        ack,
  output logic                    a_valid,
  output logic signed [DATA_W-1:0] a_data,
  output logic [ID_W-1:0]         a_id,
  input  logic                    a_ready,
  output logic                    busy
);
  import activation_arbiter_pkg::*;

  logic                     r_s1_v;
  logic signed [DATA_W-1:0] r_s1_z;
  logic [ID_W-1:0]          r_s1_id;
  logic [ID_W-1:0]          r_last;

  logic                     w_s2_adv;
  logic                     w_s1_adv;
  logic [MAX_REQ-1:0]       w_req_ext;
  logic [4:0]               w_sel;
  logic                     w_grant;
  logic [ID_W-1:0]          w_win;
  logic signed [DATA_W-1:0] w_win_z;
  logic signed [DATA_W-1:0] w_act;

  assign w_s2_adv = !a_valid || a_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;

  always_comb begin
    w_req_ext = '0;
    w_req_ext[N_REQ-1:0] = req;
  end

  assign w_sel   = rrNext(w_req_ext, 4'(r_last), N_REQ);
  assign w_win   = w_sel[ID_W-1:0];
  // Gating with rst keeps ack quiet while the design is held in reset.
  assign w_grant = rst && w_s1_adv && w_sel[4] && (int'(w_sel[3:0]) < N_REQ);
  assign w_win_z = z_value[int'(w_win)*DATA_W +: DATA_W];

  always_comb begin
    ack = '0;
    if (w_grant) ack[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v  <= 1'b0;
      r_s1_z  <= '0;
      r_s1_id <= '0;
      r_last  <= ID_W'(N_REQ - 1);
    end else if (w_s1_adv) begin
      if (w_grant) begin
        r_s1_v  <= 1'b1;
        r_s1_z  <= w_win_z;
        r_s1_id <= w_win;
        r_last  <= w_win;
      end else begin
        r_s1_v  <= 1'b0;
      end
    end
  end

  act_lut_interp u_act (
    .z_value (r_s1_z),
    .a       (w_act)
  );

  // Data and tag only move with a valid S1 entry so bubbles leave the last result visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_id    <= '0;
    end else if (w_s2_adv) begin
      a_valid <= r_s1_v;
      if (r_s1_v) begin
        a_data <= w_act;
        a_id   <= r_s1_id;
      end
    end
  end

  assign busy = r_s1_v || a_valid;

endmodule

// File: tb/tb_activation_arbiter.sv
// Self-checking bench for activation_arbiter: table of single-request vectors,
// hand sequences for ordering/stall/reset corners, and a randomized run against a queue model.
module tb_activation_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   zValue = '0;
  logic [N-1:0]      ack;
  logic              aValid;
  logic signed [DW-1:0] aData;
  logic [IW-1:0]     aId;
  logic              aReady = 1'b1;
  logic              busy;

  always #5 clk = ~clk;

  activation_arbiter #(.N_REQ(N), .ID_W(IW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .z_value (zValue),
    .ack     (ack),
    .a_valid (aValid),
    .a_data  (aData),
    .a_id    (aId),
    .a_ready (aReady),
    .busy    (busy)
  );

  typedef struct { int id; int data; int vis; } result_t;
  typedef struct { int id; logic [7:0] z; int expData; } vec_t;

  int vectors = 0;
  int miscompares = 0;
  result_t q[$];
  int lastW = N - 1;
  int cyc = 0;
  logic [N-1:0] mAck = '0;
  logic mGrant = 1'b0;
  int mWin = -1;
  logic [N-1:0] sAck;
  logic sValid, sBusy;
  int sData, sId;

  // Sigmoid of integer k in Q4.4, k = -8..7.
  function automatic int sigmoidQ(int k);
    int t[16] = '{0, 0, 0, 0, 0, 1, 2, 4, 8, 12, 14, 15, 16, 16, 16, 16};
    return t[k + 8];
  endfunction

  function automatic int actModel(logic [7:0] z);
    int zs, k, frac, lo, hi, r;
    zs   = int'($signed(z));
    k    = zs >>> 4;
    frac = zs - 16 * k;
    lo   = sigmoidQ(k);
    hi   = (k == 7) ? lo : sigmoidQ(k + 1);
    r    = lo + ((hi - lo) * frac) / 16;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic checkEq(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(logic [N-1:0] r, logic rdy);
    req    = r;
    aReady = rdy;
  endtask

  task automatic setZ(int i, logic [7:0] z);
    zValue[i*DW +: DW] = z;
  endtask

  task automatic checkOutput();
    logic headVis, canGrant;
    sAck   = ack;
    sValid = aValid;
    sBusy  = busy;
    sData  = int'(aData);
    sId    = int'(aId);
    headVis  = (q.size() > 0) && (q[0].vis <= cyc);
    canGrant = (q.size() < 2) || (headVis && aReady);
    mWin = -1;
    if (canGrant) begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (lastW + i) % N;
        if (req[c] && mWin < 0) mWin = c;
      end
    end
    mGrant = (mWin >= 0);
    mAck = '0;
    if (mGrant) mAck[mWin] = 1'b1;
    checkEq("ack", int'(sAck), int'(mAck));
    checkEq("a_valid", int'(sValid), int'(headVis));
    checkEq("busy", int'(sBusy), int'(q.size() > 0));
    if (headVis) begin
      checkEq("a_id", sId, q[0].id);
      checkEq("a_data", sData, q[0].data);
    end
  endtask

  task automatic modelUpdate();
    logic headVis;
    result_t r;
    headVis = (q.size() > 0) && (q[0].vis <= cyc);
    if (headVis && aReady) begin
      void'(q.pop_front());
      if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
    end
    if (mGrant) begin
      r.id   = mWin;
      r.data = actModel(zValue[mWin*DW +: DW]);
      r.vis  = cyc + 2;
      q.push_back(r);
      lastW = mWin;
    end
    cyc++;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic modelReset();
    q.delete();
    lastW = N - 1;
    mAck = '0;
    mGrant = 1'b0;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    applyStimulus('1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst_a_valid", int'(aValid), 0);
    checkEq("rst_busy", int'(busy), 0);
    checkEq("rst_ack", int'(ack), 0);
    checkEq("rst_a_data", int'(aData), 0);
    checkEq("rst_a_id", int'(aId), 0);
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
  endtask

  vec_t tbl[13];

  initial begin
    int cnt, n1;
    tbl[0]  = '{2, 8'h00, 8};
    tbl[1]  = '{1, 8'h18, 13};
    tbl[2]  = '{3, 8'h7F, 16};
    tbl[3]  = '{0, 8'h10, 12};
    tbl[4]  = '{1, 8'h08, 10};
    tbl[5]  = '{2, 8'hF0, 4};
    tbl[6]  = '{3, 8'hF8, 6};
    tbl[7]  = '{0, 8'h80, 0};
    tbl[8]  = '{1, 8'hC8, 0};
    tbl[9]  = '{2, 8'hD8, 1};
    tbl[10] = '{3, 8'h2C, 14};
    tbl[11] = '{0, 8'h34, 15};
    tbl[12] = '{1, 8'hEC, 3};

    #2;
    resetDut();

    for (int v = 0; v < 13; v++) begin
      setZ(tbl[v].id, tbl[v].z);
      applyStimulus(N'(1 << tbl[v].id), 1'b1);
      stepCycle();
      checkEq("tbl_ack", int'(sAck), 1 << tbl[v].id);
      applyStimulus('0, 1'b1);
      stepCycle();
      stepCycle();
      checkEq("tbl_valid", int'(sValid), 1);
      checkEq("tbl_id", sId, tbl[v].id);
      checkEq("tbl_data", sData, tbl[v].expData);
      stepCycle();
    end

    resetDut();
    for (int i = 0; i < N; i++) setZ(i, 8'(16 * i + 3));
    applyStimulus('1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      checkEq("rr_ack", int'(sAck), 1 << (k % N));
      if (k >= 2) begin
        checkEq("rr_valid", int'(sValid), 1);
        checkEq("rr_id", sId, (k - 2) % N);
      end
    end

    for (int c = 0; c < 12; c++) begin
      aReady = !(c >= 3 && c <= 7);
      stepCycle();
      if (c >= 3 && c <= 7) begin
        checkEq("bp_ack", int'(sAck), 0);
        checkEq("bp_busy", int'(sBusy), 1);
      end
    end
    applyStimulus('0, 1'b1);
    repeat (3) stepCycle();

    resetDut();
    setZ(0, 8'h21);
    setZ(2, 8'hE4);
    applyStimulus(4'b0001, 1'b0);
    stepCycle();
    checkEq("drop_ack0", int'(sAck), 4'b0001);
    applyStimulus(4'b0100, 1'b0);
    stepCycle();
    checkEq("drop_ack2", int'(sAck), 4'b0100);
    applyStimulus(4'b0010, 1'b0);
    stepCycle();
    checkEq("drop_ack1", int'(sAck), 0);
    applyStimulus('0, 1'b1);
    cnt = 0;
    n1 = 0;
    for (int c = 0; c < 4; c++) begin
      stepCycle();
      if (sValid) begin
        cnt++;
        if (sId == 1) n1++;
      end
    end
    checkEq("drop_drain_count", cnt, 2);
    checkEq("drop_id1_results", n1, 0);

    applyStimulus('1, 1'b0);
    repeat (3) stepCycle();
    checkEq("mr_busy_before", int'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    checkEq("mr_a_valid", int'(aValid), 0);
    checkEq("mr_busy", int'(busy), 0);
    checkEq("mr_ack", int'(ack), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    modelReset();
    applyStimulus('1, 1'b1);
    stepCycle();
    checkEq("mr_first_ack", int'(sAck), 4'b0001);
    applyStimulus('0, 1'b1);
    repeat (3) stepCycle();

    resetDut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !mAck[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(0, 2) != 0);
          if (req[i]) setZ(i, 8'($urandom));
        end
      end
      aReady = ($urandom_range(0, 3) != 0);
      stepCycle();
    end
    applyStimulus('0, 1'b1);
    repeat (4) stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
